// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared types and bus widths for the register-file
// write-port arbiter.
//   lu_res_t   : one buffered long-latency-unit result {dest, data, pc}
//   rf_wport_t : register-file write port {we, waddr, wdata}, same layout
//                as the WB-to-regfile bus
//   grant_e    : which requester owns the write port this cycle
package rf_wb_arbiter_pkg;

  localparam int LU_RES_BUS_WD   = 69;
  localparam int RF_WPORT_BUS_WD = 38;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } lu_res_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wport_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LU   = 2'd2
  } grant_e;

  // One-hot GPR select used by the pending-destination scoreboard.
  function automatic logic [31:0] gpr_onehot(input logic [4:0] idx);
    gpr_onehot = 32'h1 << idx;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: small synchronous FIFO holding long-latency-unit results until
// they win the register-file write port.
//   clk, resetn      : clock, asynchronous active-low reset
//   push_valid/ready : enqueue handshake (ready = not full)
//   push_data        : entry to enqueue
//   pop              : dequeue the head (ignored when empty)
//   head_valid/data  : registered head; a pushed entry appears here no
//                      earlier than the following cycle (no bypass)
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             empty;
  logic             full;
  logic             push_fire;
  logic             pop_fire;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready depends only on the registered full flag, so a pop in the same
  // cycle does not open a slot until the next cycle.
  assign push_ready = !full;
  assign push_fire  = push_valid && !full;
  assign pop_fire   = pop && !empty;

  assign head_valid = !empty;
  assign head_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_fire) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only visible once a pointer covers it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// in-order WB stage and late-retiring long-latency-unit (LU) results.
//   clk, resetn              : clock, asynchronous active-low reset
//   wb_*                     : retiring WB instruction; wb_ready low means
//                              WB must hold its bus this cycle
//   lu_issue_valid/dest      : LU op issued from ID (sets scoreboard bit)
//   lu_res_*                 : LU result handshake into the buffer FIFO
//   lu_pend_mask             : GPRs still awaiting an LU write
//   rf_we/waddr/wdata        : regfile write port
//   debug_wb_*               : trace interface mirroring the write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_ready,
  input  logic        lu_issue_valid,
  input  logic [4:0]  lu_issue_dest,
  input  logic        lu_res_valid,
  output logic        lu_res_ready,
  input  logic [4:0]  lu_res_dest,
  input  logic [31:0] lu_res_data,
  input  logic [31:0] lu_res_pc,
  output logic [31:0] lu_pend_mask,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]              starve_q, starve_d;
  logic [31:0]                pend_q, pend_d;
  lu_res_t                    push_res;
  lu_res_t                    head_res;
  logic                       head_valid;
  logic                       wb_need;
  logic                       lu_need;
  logic                       starved;
  logic                       lu_pop;
  grant_e                     grant;
  rf_wport_t                  wport;
  logic [RF_WPORT_BUS_WD-1:0] wport_bus;
  logic [31:0]                set_vec;
  logic [31:0]                clr_vec;

  assign push_res = '{dest: lu_res_dest, data: lu_res_data, pc: lu_res_pc};

  rf_wb_fifo #(
    .DEPTH (LU_DEPTH),
    .WIDTH (LU_RES_BUS_WD)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_valid (lu_res_valid),
    .push_ready (lu_res_ready),
    .push_data  (push_res),
    .pop        (lu_pop),
    .head_valid (head_valid),
    .head_data  (head_res)
  );

  // WB demand is masked while reset is held so the write port stays quiet
  // even if the flushed pipeline still presents a valid WB bus.
  assign wb_need = resetn && wb_valid && wb_we && (wb_dest != 5'd0);
  assign lu_need = head_valid;
  assign starved = (starve_q == CW'(STARVE_MAX));

  // WB normally wins; a starved LU head takes the port and stalls WB.
  always_comb begin
    grant = GNT_NONE;
    if (lu_need && (!wb_need || starved)) begin
      grant = GNT_LU;
    end else if (wb_need) begin
      grant = GNT_WB;
    end
  end

  assign lu_pop   = (grant == GNT_LU);
  assign wb_ready = !(wb_need && lu_need && starved);

  // Counts conflicts lost by the LU head; any pop restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (lu_pop) begin
      starve_d = '0;
    end else if (wb_need && lu_need && !starved) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // An LU entry for r0 still consumes its port slot (so it is traced) but
  // must not write the regfile.
  always_comb begin
    wport       = '0;
    debug_wb_pc = '0;
    case (grant)
      GNT_WB: begin
        wport.we    = 1'b1;
        wport.waddr = wb_dest;
        wport.wdata = wb_data;
        debug_wb_pc = wb_pc;
      end
      GNT_LU: begin
        wport.we    = (head_res.dest != 5'd0);
        wport.waddr = head_res.dest;
        wport.wdata = head_res.data;
        debug_wb_pc = head_res.pc;
      end
      default: begin
        wport       = '0;
        debug_wb_pc = '0;
      end
    endcase
  end

  assign wport_bus                     = wport;
  assign {rf_we, rf_waddr, rf_wdata}   = wport_bus;
  assign debug_wb_rf_we                = {4{rf_we}};
  assign debug_wb_rf_wnum              = rf_waddr;
  assign debug_wb_rf_wdata             = rf_wdata;

  // Set and clear are independent vectors; ID never issues to a pending
  // register, so the same bit cannot be set and cleared together.
  always_comb begin
    set_vec = (lu_issue_valid && (lu_issue_dest != 5'd0)) ? gpr_onehot(lu_issue_dest) : 32'h0;
    clr_vec = lu_pop ? gpr_onehot(head_res.dest) : 32'h0;
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  assign lu_pend_mask = pend_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed bench for rf_wb_arbiter (LU_DEPTH=2,
// STARVE_MAX=4). Inputs change on the falling edge and outputs are sampled
// 1ns later; expected values are written out by hand per step.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        resetn;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        wb_ready;
  logic        lu_issue_valid;
  logic [4:0]  lu_issue_dest;
  logic        lu_res_valid;
  logic        lu_res_ready;
  logic [4:0]  lu_res_dest;
  logic [31:0] lu_res_data;
  logic [31:0] lu_res_pc;
  logic [31:0] lu_pend_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int vectors;
  int miscompares;

  rf_wb_arbiter #(
    .LU_DEPTH   (2),
    .STARVE_MAX (4)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_valid          (wb_valid),
    .wb_we             (wb_we),
    .wb_dest           (wb_dest),
    .wb_data           (wb_data),
    .wb_pc             (wb_pc),
    .wb_ready          (wb_ready),
    .lu_issue_valid    (lu_issue_valid),
    .lu_issue_dest     (lu_issue_dest),
    .lu_res_valid      (lu_res_valid),
    .lu_res_ready      (lu_res_ready),
    .lu_res_dest       (lu_res_dest),
    .lu_res_data       (lu_res_data),
    .lu_res_pc         (lu_res_pc),
    .lu_pend_mask      (lu_pend_mask),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus sanity: ID must never issue to a register that is still pending.
  always @(posedge clk) begin
    if (resetn && lu_issue_valid && (lu_issue_dest != 5'd0)) begin
      assert (lu_pend_mask[lu_issue_dest] === 1'b0) else begin
        miscompares++;
        $error("[TB] FAIL issue_to_pending: observed mask %h dest %0d required bit clear",
               lu_pend_mask, lu_issue_dest);
      end
    end
  end

  // Drives one cycle of inputs on the falling edge and waits 1ns to sample.
  task automatic applyStimulus(
    input logic wv, input logic we, input logic [4:0] wd, input logic [31:0] wdat,
    input logic [31:0] wpc, input logic iv, input logic [4:0] id, input logic rv,
    input logic [4:0] rd, input logic [31:0] rdat, input logic [31:0] rpc);
    @(negedge clk);
    wb_valid       = wv;
    wb_we          = we;
    wb_dest        = wd;
    wb_data        = wdat;
    wb_pc          = wpc;
    lu_issue_valid = iv;
    lu_issue_dest  = id;
    lu_res_valid   = rv;
    lu_res_dest    = rd;
    lu_res_data    = rdat;
    lu_res_pc      = rpc;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkPort(input string tag, input logic we, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic [31:0] pc);
    checkOutput({tag, "_we"},    32'(rf_we), 32'(we));
    checkOutput({tag, "_waddr"}, 32'(rf_waddr), 32'(waddr));
    checkOutput({tag, "_wdata"}, rf_wdata, wdata);
    checkOutput({tag, "_dpc"},   debug_wb_pc, pc);
    checkOutput({tag, "_dwe"},   32'(debug_wb_rf_we), {28'h0, {4{we}}});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b1;
    wb_valid = 1; wb_we = 1; wb_dest = 5; wb_data = 32'h1234; wb_pc = 32'h80;
    lu_issue_valid = 0; lu_issue_dest = 0;
    lu_res_valid = 0; lu_res_dest = 0; lu_res_data = 0; lu_res_pc = 0;

    // Reset asserted with WB presenting a write: port must stay silent.
    #1 resetn = 1'b0;
    #2;
    checkPort("rst", 0, 0, 0, 0);
    checkOutput("rst_wnum",   32'(debug_wb_rf_wnum), 0);
    checkOutput("rst_wdbg",   debug_wb_rf_wdata, 0);
    checkOutput("rst_ready",  32'(lu_res_ready), 1);
    checkOutput("rst_wbrdy",  32'(wb_ready), 1);
    checkOutput("rst_mask",   lu_pend_mask, 0);

    // Release: WB write goes straight through in the same cycle.
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkPort("wb1", 1, 5, 32'h1234, 32'h80);
    checkOutput("wb1_wnum",  32'(debug_wb_rf_wnum), 5);
    checkOutput("wb1_wbrdy", 32'(wb_ready), 1);

    // LU issue to r7, then its result retires one cycle after enqueue.
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    checkOutput("iss_mask0", lu_pend_mask, 0);
    checkPort("iss_idle", 0, 0, 0, 0);
    idle();
    checkOutput("iss_mask1", lu_pend_mask, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hAA, 32'h100);
    checkOutput("enq_ready", 32'(lu_res_ready), 1);
    checkOutput("enq_nobyp", 32'(rf_we), 0);
    idle();
    checkPort("lu7", 1, 7, 32'hAA, 32'h100);
    checkOutput("lu7_mask", lu_pend_mask, 32'h80);
    idle();
    checkOutput("lu7_clr", lu_pend_mask, 0);
    checkOutput("lu7_idle", 32'(rf_we), 0);

    // Starvation: WB writes every cycle; the LU head wins on its 5th try.
    applyStimulus(1, 1, 3, 32'h3, 32'h500, 0, 0, 1, 9, 32'h99, 32'h200);
    checkPort("st0", 1, 3, 32'h3, 32'h500);
    checkOutput("st0_wbrdy", 32'(wb_ready), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 5'(11 + i), 32'(32'h11 + i), 32'(32'h504 + 4 * i), 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("st%0d_waddr", i + 1), 32'(rf_waddr), 32'(11 + i));
      checkOutput($sformatf("st%0d_wbrdy", i + 1), 32'(wb_ready), 1);
    end
    applyStimulus(1, 1, 15, 32'h15, 32'h514, 0, 0, 0, 0, 0, 0);
    checkPort("st5_lu", 1, 9, 32'h99, 32'h200);
    checkOutput("st5_wbrdy", 32'(wb_ready), 0);
    applyStimulus(1, 1, 15, 32'h15, 32'h514, 0, 0, 0, 0, 0, 0);
    checkPort("st6_held", 1, 15, 32'h15, 32'h514);
    checkOutput("st6_wbrdy", 32'(wb_ready), 1);

    // Fill the FIFO behind a busy WB; third result waits for space.
    applyStimulus(1, 1, 16, 32'h16, 32'h600, 0, 0, 1, 20, 32'hA20, 32'h700);
    checkOutput("f0_ready", 32'(lu_res_ready), 1);
    checkOutput("f0_waddr", 32'(rf_waddr), 16);
    applyStimulus(1, 1, 17, 32'h17, 32'h604, 0, 0, 1, 21, 32'hA21, 32'h704);
    checkOutput("f1_ready", 32'(lu_res_ready), 1);
    checkOutput("f1_waddr", 32'(rf_waddr), 17);
    applyStimulus(1, 1, 18, 32'h18, 32'h608, 0, 0, 1, 22, 32'hA22, 32'h708);
    checkOutput("f2_full", 32'(lu_res_ready), 0);
    checkOutput("f2_waddr", 32'(rf_waddr), 18);
    applyStimulus(1, 1, 19, 32'h19, 32'h60C, 0, 0, 1, 22, 32'hA22, 32'h708);
    checkOutput("f3_full", 32'(lu_res_ready), 0);
    applyStimulus(1, 1, 23, 32'h23, 32'h610, 0, 0, 1, 22, 32'hA22, 32'h708);
    checkOutput("f4_full", 32'(lu_res_ready), 0);
    checkOutput("f4_waddr", 32'(rf_waddr), 23);
    applyStimulus(1, 1, 24, 32'h24, 32'h614, 0, 0, 1, 22, 32'hA22, 32'h708);
    checkPort("f5_lu", 1, 20, 32'hA20, 32'h700);
    checkOutput("f5_wbrdy", 32'(wb_ready), 0);
    checkOutput("f5_norefill", 32'(lu_res_ready), 0);
    applyStimulus(1, 1, 24, 32'h24, 32'h614, 0, 0, 1, 22, 32'hA22, 32'h708);
    checkOutput("f6_waddr", 32'(rf_waddr), 24);
    checkOutput("f6_wbrdy", 32'(wb_ready), 1);
    checkOutput("f6_ready", 32'(lu_res_ready), 1);
    idle();
    checkPort("f7_lu", 1, 21, 32'hA21, 32'h704);
    idle();
    checkPort("f8_lu", 1, 22, 32'hA22, 32'h708);
    idle();
    checkOutput("f9_empty", 32'(rf_we), 0);

    // WB with no register write alongside a queued LU head.
    applyStimulus(0, 0, 0, 0, 0, 1, 6, 1, 12, 32'hC0, 32'h300);
    checkOutput("g0_idle", 32'(rf_we), 0);
    applyStimulus(1, 0, 4, 32'hDEAD, 32'h800, 0, 0, 0, 0, 0, 0);
    checkPort("g1_lu", 1, 12, 32'hC0, 32'h300);
    checkOutput("g1_wbrdy", 32'(wb_ready), 1);
    checkOutput("g1_mask", lu_pend_mask, 32'h40);

    // LU result for r0: traced but not written; issue to r0 ignored.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h55, 32'h400);
    checkOutput("h0_mask", lu_pend_mask, 32'h40);
    idle();
    checkPort("h1_r0", 0, 0, 32'h55, 32'h400);
    checkOutput("h1_mask", lu_pend_mask, 32'h40);
    idle();
    checkOutput("h2_dpc", debug_wb_pc, 0);

    // Set one bit while clearing another in the same cycle.
    applyStimulus(0, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 13, 32'hD, 32'h410);
    checkOutput("k1_mask", lu_pend_mask, 32'h2040);
    applyStimulus(0, 0, 0, 0, 0, 1, 17, 0, 0, 0, 0);
    checkOutput("k2_waddr", 32'(rf_waddr), 13);
    idle();
    checkOutput("k3_mask", lu_pend_mask, 32'h20040);

    // Reset mid-operation discards the queued result and the mask.
    applyStimulus(0, 0, 0, 0, 0, 1, 25, 1, 26, 32'h1, 32'h420);
    idle();
    checkOutput("m1_head", 32'(rf_waddr), 26);
    resetn = 1'b0;
    #1;
    checkOutput("m1_rst_mask", lu_pend_mask, 0);
    checkOutput("m1_rst_we", 32'(rf_we), 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    idle();
    checkOutput("m2_we", 32'(rf_we), 0);
    checkOutput("m2_mask", lu_pend_mask, 0);
    checkOutput("m2_ready", 32'(lu_res_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
